// File: rtl/beamformer_pkg.sv
// Shared constants, state encoding and delay arithmetic for the beamformer steering path.
package beamformer_pkg;

    localparam int GRID_DIM      = 5;
    localparam int NUM_MICS      = GRID_DIM * GRID_DIM;
    localparam int DELAY_W       = 8;
    localparam int ANGLE_W       = 8;
    localparam int ROM_ADDR_W    = 9;
    localparam int ROM_ROW_SHIFT = 6;
    localparam int IDX_W         = 5;
    localparam int COORD_W       = 3;

    localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_DIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } load_state_t;

    // Returns {saturated, value}; a carry out clamps the delay to all ones.
    function automatic logic [DELAY_W:0] sat_sum(input logic [DELAY_W-1:0] a,
                                                 input logic [DELAY_W-1:0] b);
        logic [DELAY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DELAY_W]) begin
            sat_sum = {1'b1, {DELAY_W{1'b1}}};
        end else begin
            sat_sum = s;
        end
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer for an asynchronous control plus rising-edge detection.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/steer_delay_loader.sv
// Walks the mic grid, sums ROM horizontal/vertical delays into the shadow delay file, then commits.
module steer_delay_loader
    import beamformer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  steer_req_async,
    input  logic [ANGLE_W-1:0]    steer_hori,
    input  logic [ANGLE_W-1:0]    steer_vert,
    output logic                  rom_rd_en,
    output logic [ROM_ADDR_W-1:0] rom_addr_hori,
    output logic [ROM_ADDR_W-1:0] rom_addr_vert,
    input  logic [DELAY_W-1:0]    rom_q_hori,
    input  logic [DELAY_W-1:0]    rom_q_vert,
    output logic                  dly_we,
    output logic [IDX_W-1:0]      dly_idx,
    output logic [DELAY_W-1:0]    dly_val,
    output logic                  dly_commit,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_err
);

    logic                w_req_pulse;
    load_state_t         r_state;
    load_state_t         w_state_nxt;
    logic                w_take;
    logic                w_last;
    logic [COORD_W-1:0]  r_row;
    logic [COORD_W-1:0]  r_col;
    logic [IDX_W-1:0]    r_mic;
    logic [ANGLE_W-1:0]  r_hori;
    logic [ANGLE_W-1:0]  r_vert;
    logic                r_pend;
    logic [ANGLE_W-1:0]  r_pend_hori;
    logic [ANGLE_W-1:0]  r_pend_vert;
    logic                r_we;
    logic [IDX_W-1:0]    r_idx;
    logic                r_sat_err;
    logic [DELAY_W:0]    w_sum;

    sync_rise_det u_req_det (
        .clk     (clk),
        .rst     (rst),
        .i_async (steer_req_async),
        .o_pulse (w_req_pulse)
    );

    assign w_last = (r_row == COORD_MAX) && (r_col == COORD_MAX);
    assign w_sum  = sat_sum(rom_q_hori, rom_q_vert);

    // Next-state decode; a request is taken only from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_pulse || r_pend) begin
                    w_state_nxt = ST_ISSUE;
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN:  w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, grid walk and angle capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_mic   <= '0;
            r_hori  <= '0;
            r_vert  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                // A fresh edge carries the newest angles; otherwise replay the queued ones
                r_hori <= w_req_pulse ? steer_hori : r_pend_hori;
                r_vert <= w_req_pulse ? steer_vert : r_pend_vert;
                r_row  <= '0;
                r_col  <= '0;
                r_mic  <= '0;
            end else if (r_state == ST_ISSUE) begin
                if (r_col == COORD_MAX) begin
                    r_col <= '0;
                    r_row <= r_row + COORD_W'(1);
                end else begin
                    r_col <= r_col + COORD_W'(1);
                end
                r_mic <= r_mic + IDX_W'(1);
            end
        end
    end

    // One-deep pending request; newer requests overwrite the queued angles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_hori <= '0;
            r_pend_vert <= '0;
        end else if (w_take) begin
            r_pend <= 1'b0;
        end else if (w_req_pulse && (r_state != ST_IDLE)) begin
            r_pend      <= 1'b1;
            r_pend_hori <= steer_hori;
            r_pend_vert <= steer_vert;
        end
    end

    // Write stage aligned with ROM read latency, plus sticky saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_sat_err <= 1'b0;
        end else begin
            r_we  <= (r_state == ST_ISSUE);
            r_idx <= r_mic;
            if (w_take) begin
                r_sat_err <= 1'b0;
            end else if (r_we && w_sum[DELAY_W]) begin
                r_sat_err <= 1'b1;
            end
        end
    end

    // Output decode from registered state; addresses and data are zero outside their windows
    always_comb begin
        rom_rd_en     = 1'b0;
        rom_addr_hori = '0;
        rom_addr_vert = '0;
        dly_val       = '0;
        if (r_state == ST_ISSUE) begin
            rom_rd_en     = 1'b1;
            rom_addr_hori = (ROM_ADDR_W'(r_col) << ROM_ROW_SHIFT) + ROM_ADDR_W'(r_hori);
            rom_addr_vert = (ROM_ADDR_W'(r_row) << ROM_ROW_SHIFT) + ROM_ADDR_W'(r_vert);
        end else begin
            rom_rd_en = 1'b0;
        end
        if (r_we) begin
            dly_val = w_sum[DELAY_W-1:0];
        end else begin
            dly_val = '0;
        end
    end

    assign dly_we     = r_we;
    assign dly_idx    = r_idx;
    assign dly_commit = (r_state == ST_COMMIT);
    assign done       = (r_state == ST_COMMIT);
    assign busy       = (r_state != ST_IDLE);
    assign sat_err    = r_sat_err;

endmodule

// File: tb/tb_steer_delay_loader.sv
// Directed bench for steer_delay_loader: ROM model, expected-write scoreboard and commit timing checks.
module tb_steer_delay_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       steer_req_async;
    logic [7:0] steer_hori;
    logic [7:0] steer_vert;
    logic       rom_rd_en;
    logic [8:0] rom_addr_hori;
    logic [8:0] rom_addr_vert;
    logic [7:0] rom_q_hori = 8'h00;
    logic [7:0] rom_q_vert = 8'h00;
    logic       dly_we;
    logic [4:0] dly_idx;
    logic [7:0] dly_val;
    logic       dly_commit;
    logic       busy;
    logic       done;
    logic       sat_err;

    int total = 0;
    int bad = 0;
    int rom_mode = 0;
    int cyc = 0;
    int commits = 0;
    int start_cyc = 0;
    int last_commit_cyc = -1000;
    int start_gap = 0;
    int nwr = 0;
    logic prev_busy = 1'b0;
    logic [12:0] exp_q[$];

    steer_delay_loader dut (
        .clk             (clk),
        .rst             (rst),
        .steer_req_async (steer_req_async),
        .steer_hori      (steer_hori),
        .steer_vert      (steer_vert),
        .rom_rd_en       (rom_rd_en),
        .rom_addr_hori   (rom_addr_hori),
        .rom_addr_vert   (rom_addr_vert),
        .rom_q_hori      (rom_q_hori),
        .rom_q_vert      (rom_q_vert),
        .dly_we          (dly_we),
        .dly_idx         (dly_idx),
        .dly_val         (dly_val),
        .dly_commit      (dly_commit),
        .busy            (busy),
        .done            (done),
        .sat_err         (sat_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(int mode, int port, logic [8:0] addr);
        logic [7:0] w;
        w = 8'h00;
        if (mode == 1) w = addr[7:0];
        else if (mode == 2 && port == 0 && addr == 9'h010) w = 8'h90;
        else if (mode == 2 && port == 1 && addr == 9'h020) w = 8'h80;
        return w;
    endfunction

    function automatic logic [7:0] exp_val(int mode, int i, logic [7:0] h, logic [7:0] v);
        int col;
        int row;
        int s;
        logic [8:0] ha;
        logic [8:0] va;
        col = i % 5;
        row = i / 5;
        ha = 9'((col * 64 + int'(h)) % 512);
        va = 9'((row * 64 + int'(v)) % 512);
        s = int'(rom_word(mode, 0, ha)) + int'(rom_word(mode, 1, va));
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_load(int mode, logic [7:0] h, logic [7:0] v);
        for (int i = 0; i < 25; i++) begin
            exp_q.push_back({5'(i), exp_val(mode, i, h, v)});
        end
    endtask

    task automatic req(logic [7:0] h, logic [7:0] v);
        steer_hori = h;
        steer_vert = v;
        steer_req_async = 1'b1;
        repeat (4) @(negedge clk);
        steer_req_async = 1'b0;
        repeat (3) @(negedge clk);
        steer_hori = 8'($urandom);
        steer_vert = 8'($urandom);
    endtask

    task automatic wait_commits(int n, int budget);
        for (int i = 0; i < budget && commits < n; i++) @(posedge clk);
        chk("commit_count_reached", 32'(commits >= n), 32'd1);
    endtask

    task automatic wait_busy(int budget);
        for (int i = 0; i < budget && !busy; i++) @(negedge clk);
        chk("busy_seen", 32'(busy), 32'd1);
    endtask

    // ROM model: registered read, one cycle of latency behind the enable
    always @(posedge clk) begin
        if (rom_rd_en) begin
            rom_q_hori <= rom_word(rom_mode, 0, rom_addr_hori);
            rom_q_vert <= rom_word(rom_mode, 1, rom_addr_vert);
        end
    end

    // Monitor: scoreboard pop on each write, commit timing and write count
    always @(negedge clk) begin
        logic [12:0] e;
        cyc++;
        if (rst) begin
            prev_busy = 1'b0;
            nwr = 0;
        end else begin
            if (busy && !prev_busy) begin
                start_gap = cyc - last_commit_cyc;
                start_cyc = cyc;
                nwr = 0;
            end
            if (dly_we) begin
                nwr++;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dly_idx", 32'(dly_idx), 32'(e[12:8]));
                    chk("dly_val", 32'(dly_val), 32'(e[7:0]));
                end
            end
            if (dly_commit) begin
                commits++;
                last_commit_cyc = cyc;
                chk("done_with_commit", 32'(done), 32'd1);
                chk("commit_latency", 32'(cyc - start_cyc), 32'd26);
                chk("writes_per_load", 32'(nwr), 32'd25);
            end
            prev_busy = busy;
        end
    end

    initial begin
        rst = 1'b1;
        steer_req_async = 1'b0;
        steer_hori = 8'h00;
        steer_vert = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(dly_we), 32'd0);
        chk("rst_rd_en", 32'(rom_rd_en), 32'd0);
        chk("rst_commit", 32'(dly_commit), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sat", 32'(sat_err), 32'd0);
        chk("rst_addr", 32'({rom_addr_hori, rom_addr_vert}), 32'd0);
        rst = 1'b0;

        // 1: all-zero ROM
        rom_mode = 0;
        push_load(0, 8'd0, 8'd0);
        req(8'd0, 8'd0);
        wait_commits(1, 200);
        chk("t1_sat", 32'(sat_err), 32'd0);

        // 2: address-pattern ROM, mic (2,4) reads 259/133
        @(negedge clk);
        rom_mode = 1;
        push_load(1, 8'd3, 8'd5);
        req(8'd3, 8'd5);
        wait_commits(2, 200);

        // 3: saturation at mic 0, sticky until next accepted request
        @(negedge clk);
        rom_mode = 2;
        push_load(2, 8'h10, 8'h20);
        req(8'h10, 8'h20);
        wait_commits(3, 200);
        repeat (5) @(negedge clk);
        chk("t3_sat_held", 32'(sat_err), 32'd1);
        chk("t3_done_low", 32'(done), 32'd0);
        rom_mode = 0;
        push_load(0, 8'd0, 8'd0);
        steer_hori = 8'd0;
        steer_vert = 8'd0;
        steer_req_async = 1'b1;
        wait_busy(20);
        chk("t3_sat_cleared", 32'(sat_err), 32'd0);
        steer_req_async = 1'b0;
        wait_commits(4, 200);

        // 4: two requests during a load collapse into one extra load with the newest angles
        repeat (3) @(negedge clk);
        rom_mode = 1;
        push_load(1, 8'h40, 8'h7F);
        req(8'h40, 8'h7F);
        wait_busy(20);
        repeat (6) @(negedge clk);
        req(8'd7, 8'd9);
        push_load(1, 8'd1, 8'd2);
        req(8'd1, 8'd2);
        chk("t4_still_busy", 32'(busy), 32'd1);
        wait_commits(6, 300);
        chk("t4_back_to_back_gap", 32'(start_gap), 32'd2);
        repeat (40) @(negedge clk);
        chk("t4_one_extra_load", 32'(commits), 32'd6);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset mid-load aborts without commit
        push_load(1, 8'h22, 8'h11);
        req(8'h22, 8'h11);
        wait_busy(20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_we", 32'(dly_we), 32'd0);
        chk("t5_rd_en", 32'(rom_rd_en), 32'd0);
        chk("t5_commit", 32'(dly_commit), 32'd0);
        chk("t5_val_idx", 32'({dly_val, dly_idx}), 32'd0);
        chk("t5_addr", 32'({rom_addr_hori, rom_addr_vert}), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        chk("t5_no_commit", 32'(commits), 32'd6);
        rom_mode = 0;
        push_load(0, 8'd0, 8'd0);
        req(8'd0, 8'd0);
        wait_commits(7, 200);

        // 6: request held high for 100 cycles yields one load
        @(negedge clk);
        rom_mode = 1;
        push_load(1, 8'h55, 8'h33);
        steer_hori = 8'h55;
        steer_vert = 8'h33;
        steer_req_async = 1'b1;
        repeat (100) @(negedge clk);
        steer_req_async = 1'b0;
        wait_commits(8, 200);
        repeat (20) @(negedge clk);
        chk("t6_single_load", 32'(commits), 32'd8);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
